// File: rtl/banco_registradores_if.sv
// Issue/write-back/operand bus between the register file stage and its neighbours.
// The slave modport is the register file; the master modport drives it.
interface banco_registradores_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic             in_sub;
    logic             we;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] wd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             soma_sub;

    modport slave (
        input  in_valid, rs1, rs2, in_sub, we, rd, wd, out_ready,
        output in_ready, out_valid, a, b, soma_sub
    );

    modport master (
        output in_valid, rs1, rs2, in_sub, we, rd, wd, out_ready,
        input  in_ready, out_valid, a, b, soma_sub
    );
endinterface

// File: rtl/banco_registradores.sv
// 32 x 64-bit register file with write-back bypass feeding a single-entry
// valid/ready operand register that drives the ULA inputs a, b and soma_sub.
module banco_registradores #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    banco_registradores_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // Register 0 is never stored; it is forced to zero on every read.
    logic [WIDTH-1:0] regs_q [1:NREGS-1];

    logic [WIDTH-1:0] rd1_val;
    logic [WIDTH-1:0] rd2_val;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;

    logic             in_ready;
    logic             accept;
    logic             wr_en;

    assign wr_en = bus.we && (bus.rd != AW'(0));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd1_val = '0;
        if (bus.rs1 != AW'(0)) begin
            if (bus.we && (bus.rd == bus.rs1)) rd1_val = bus.wd;
            else                               rd1_val = regs_q[bus.rs1];
        end
    end

    always_comb begin
        rd2_val = '0;
        if (bus.rs2 != AW'(0)) begin
            if (bus.we && (bus.rd == bus.rs2)) rd2_val = bus.wd;
            else                               rd2_val = regs_q[bus.rs2];
        end
    end

    // NOTE: the whole array is cleared on reset because a post-reset read must return zero; this costs a reset net on every storage flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[bus.rd] <= bus.wd;
        end
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Operands are snapshots taken at accept; later write-backs never touch a held bundle.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = rd1_val;
            b_d     = rd2_val;
            sub_d   = bus.in_sub;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.soma_sub  = sub_q;
endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: a table of single-cycle vectors
// followed by hand-written backpressure and mid-transfer reset sequences.
module tb_banco_registradores;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    banco_registradores_if #(.WIDTH(64), .AW(5)) bus ();

    banco_registradores #(.WIDTH(64), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        sub;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_v;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic        exp_s;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                         input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic sub, input logic ordy);
        bus.we        = we;
        bus.rd        = rd;
        bus.wd        = wd;
        bus.in_valid  = iv;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
        bus.in_sub    = sub;
        bus.out_ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] ea,
                             input logic [63:0] eb, input logic s);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
        check({tag, ".a"},         bus.a,              ea);
        check({tag, ".b"},         bus.b,              eb);
        check({tag, ".soma_sub"},  64'(bus.soma_sub),  64'(s));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 5'd3, 64'd3, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0};
        vecs[2]  = '{1'b1, 5'd4, 64'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 64'd3, 64'd2, 1'b1};
        vecs[4]  = '{1'b1, 5'd9, 64'hDEAD_BEEF, 1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'd3, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'd3, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'd3, 1'b0};
        vecs[10] = '{1'b1, 5'd5, 64'h1234_5678_9ABC_DEF0, 1'b1, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd2, 1'b1};

        reset = 1'b1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        #2;
        check_out("reset", 1'b0, 64'h0, 64'h0, 1'b0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].iv,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].sub, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_s);
            @(negedge clk);
        end

        // Backpressure: held operand must stay a snapshot while r1 is rewritten.
        drive(1'b1, 5'd1, 64'd10, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("bp.issue", 1'b1, 64'd10, 64'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd1, 64'd20, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp.hold%0d.in_ready", c), 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            check_out($sformatf("bp.hold%0d", c), 1'b1, 64'd10, 64'h0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("bp.consume", 1'b0, 64'd10, 64'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("bp.reissue", 1'b1, 64'd20, 64'd20, 1'b0);
        @(negedge clk);

        // Reset mid-transfer clears the held bundle and the register contents.
        drive(1'b1, 5'd2, 64'd7, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 5'd2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst.pre", 1'b1, 64'd7, 64'd7, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst.async", 1'b0, 64'h0, 64'h0, 1'b0);
        check("rst.async.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 5'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("rst.post", 1'b1, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/banco_registradores.md
# banco_registradores

Register file and operand-issue stage directly upstream of the 64-bit ULA. Holds 32 x 64-bit general registers: two read ports, one write-back port, register 0 hardwired to zero. On each accepted issue request it reads two source registers, with same-cycle write-back bypass. It presents them, together with the add/subtract select, as a registered operand bundle on a valid/ready handshake that drives the ULA inputs `a`, `b` and `soma_sub`.

## Interface
- `WIDTH`, 64, register and operand width in bits (matches the ULA).
- `NREGS`, 32, number of registers; address width is log2(NREGS) = 5.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: issue request present.
- `in_ready` output 1: stage can accept an issue request this cycle.
- `rs1` input 5: source register index for operand `a`.
- `rs2` input 5: source register index for operand `b`.
- `in_sub` input 1: operation select, passed to `soma_sub` (0 = add, 1 = subtract).
- `we` input 1: write-back enable.
- `rd` input 5: write-back destination index.
- `wd` input WIDTH: write-back data (the ULA `result` or other source).
- `out_valid` output 1: operand bundle valid toward the ULA.
- `out_ready` input 1: consumer accepts the bundle this cycle.
- `a` output WIDTH: registered operand A; connects to ULA `a`.
- `b` output WIDTH: registered operand B; connects to ULA `b`.
- `soma_sub` output 1: registered operation select; connects to ULA `soma_sub`.

## Operation
- Storage: NREGS x WIDTH registers.
  - A write occurs at the clock edge when `we`=1 and `rd`!=0.
  - Writes with `rd`=0 are discarded; register 0 always reads 0.
- Read value for index `r`:
  - 0 if `r`=0;
  - otherwise `wd` if `we`=1 and `rd`=`r` (bypass: same-cycle write is visible);
  - otherwise the stored register content.
- Output stage: single-entry register holding `a`, `b`, `soma_sub`, `out_valid`.
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - Accept = `in_valid` && `in_ready`.
  - On accept: `a` <= read(`rs1`), `b` <= read(`rs2`), `soma_sub` <= `in_sub`, `out_valid` <= 1.
  - When `out_valid` && `out_ready` && !`in_valid`: `out_valid` <= 0; `a`/`b`/`soma_sub` hold their last values.
  - When `out_valid` && !`out_ready`: the bundle is frozen. A later write-back to `rs1`/`rs2` does NOT modify the held `a`/`b`; operands are snapshots taken at accept.
- Write-back is independent of the handshake: it proceeds every cycle regardless of `in_ready` or `out_ready`.
- `rs1`=`rs2` is legal: both operands receive the same value.
- No arithmetic is performed here; widths pass through unchanged.

## Timing
- Reset (asynchronous, immediate on `reset`=1):
  - all registers = 0;
  - `out_valid`=0, `a`=0, `b`=0, `soma_sub`=0;
  - `in_ready`=1 while in reset and after release.
- Write latency: a write at edge N is visible to reads from cycle N onward. Through the bypass it is also visible in the cycle the write is presented.
- Issue latency: 1 cycle. A request accepted at edge N appears on `a`/`b`/`soma_sub` with `out_valid`=1 after edge N.
- Throughput: 1 bundle per cycle while `out_ready`=1. Back-to-back accepts replace the bundle each edge.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and the outputs are stable until `out_ready` rises.
- Reset asserted mid-transfer discards any held bundle and all register contents. The first accept after reset release reads zeros unless written first.

## Test plan
- Reset then issue `rs1`=5, `rs2`=7, `in_sub`=0 -> next cycle `out_valid`=1, `a`=0, `b`=0, `soma_sub`=0.
- Write r3=3, then r4=2; issue `rs1`=3, `rs2`=4, `in_sub`=1 -> `a`=3, `b`=2, `soma_sub`=1 (ULA result 1).
- Same cycle: `we`=1, `rd`=9, `wd`=0xDEAD_BEEF, plus issue `rs1`=9, `rs2`=0 -> `a`=0xDEAD_BEEF, `b`=0. Next cycle a read of r9 returns 0xDEAD_BEEF.
- Write `rd`=0, `wd`=0xFFFF_FFFF_FFFF_FFFF; issue `rs1`=0, `rs2`=0 -> `a`=0, `b`=0, including the same-cycle bypass case.
- With r1=10 and `out_ready`=0: issue `rs1`=1, then write r1=20 and hold for 3 cycles -> `a` stays 10 and `in_ready`=0. Raise `out_ready` -> bundle consumed; a new issue of `rs1`=1 yields 20.
- Assert `reset` for 1 cycle while `out_valid`=1 and r2=7 -> `out_valid`=0 and `a`=`b`=0 immediately. A subsequent issue of `rs1`=2 gives `a`=0.
